reg_writeback_queue: RTL and testbench

Write-side companion to the per-register storage of the multicycle register file. Accepts completed results (destination register + data) from the ALU/memory stages over a valid/ready handshake, buffers them in a small in-order queue, and drains them one per cycle onto the register file write port (`rd` / `i_data`). Also reports read-after-write hazards for the current `rs`/`rt` against pending writes, with optional forwarding.

---
 rtl/reg_writeback_queue_if.sv | 34 +++
 rtl/reg_writeback_queue.sv | 119 +++++++++++
 tb/tb_reg_writeback_queue.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/reg_writeback_queue_if.sv
// Result-in / register-write-out bundle for reg_writeback_queue, plus hazard lookup.
// slave = queue side, master = producer/register-file/decode side.
interface reg_writeback_queue_if #(
    parameter int DEPTH = 4,
    parameter int DW    = 32
);
    logic                         res_valid;
    logic                         res_ready;
    logic [4:0]                   res_rd;
    logic [DW-1:0]                res_data;
    logic                         wr_stall;
    logic                         wr_en;
    logic [4:0]                   wr_rd;
    logic [DW-1:0]                wr_data;
    logic [4:0]                   rs;
    logic [4:0]                   rt;
    logic                         hazard_a;
    logic                         hazard_b;
    logic [DW-1:0]                fwd_a_data;
    logic [DW-1:0]                fwd_b_data;
    logic [$clog2(DEPTH+1)-1:0]   count;

    modport slave (
        input  res_valid, res_rd, res_data, wr_stall, rs, rt,
        output res_ready, wr_en, wr_rd, wr_data,
               hazard_a, hazard_b, fwd_a_data, fwd_b_data, count
    );

    modport master (
        output res_valid, res_rd, res_data, wr_stall, rs, rt,
        input  res_ready, wr_en, wr_rd, wr_data,
               hazard_a, hazard_b, fwd_a_data, fwd_b_data, count
    );
endinterface

// File: rtl/reg_writeback_queue.sv
// In-order writeback queue feeding the register file write port; RAW hazard report (REG_WB_FWD_EN adds forwarding).
// Latency: result accepted at edge N is presented on wr_* after N and written at N+1 (when not stalled).
// Backpressure: res_ready = !full (no pass-through when full); wr_stall holds the head in place.
module reg_writeback_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    reg_writeback_queue_if.slave  bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef struct packed {
        logic [4:0]    rd;
        logic [DW-1:0] data;
    } entry_t;

    entry_t          ent_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   cnt_q;

    logic full;
    logic empty;
    logic accept;
    logic push;
    logic pop;

    assign full   = (cnt_q == FULL_CNT);
    assign empty  = (cnt_q == '0);
    assign accept = bus.res_valid && !full;
    // r0 writes complete the handshake but never occupy a slot
    assign push   = accept && (bus.res_rd != 5'd0);
    assign pop    = !empty && !bus.wr_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            vld_q  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            // push and pop never target the same slot: equal pointers mean empty or full
            if (push) begin
                ent_q[wr_ptr] <= '{rd: bus.res_rd, data: bus.res_data};
                vld_q[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (pop) begin
                ent_q[rd_ptr] <= '0;
                vld_q[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign bus.res_ready = !full;
    assign bus.wr_en     = pop;
    assign bus.wr_rd     = empty ? 5'd0     : ent_q[rd_ptr].rd;
    assign bus.wr_data   = empty ? {DW{1'b0}} : ent_q[rd_ptr].data;
    assign bus.count     = cnt_q;

    logic hit_a;
    logic hit_b;
`ifdef REG_WB_FWD_EN
    logic [DW-1:0] fwd_a;
    logic [DW-1:0] fwd_b;
`endif

    // Walk oldest to youngest so the last match seen is the youngest pending write
    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
`ifdef REG_WB_FWD_EN
        fwd_a = '0;
        fwd_b = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            automatic logic [PW-1:0] idx = rd_ptr + PW'(k);
            if (vld_q[idx]) begin
                if (ent_q[idx].rd == bus.rs) begin
                    hit_a = 1'b1;
`ifdef REG_WB_FWD_EN
                    fwd_a = ent_q[idx].data;
`endif
                end
                if (ent_q[idx].rd == bus.rt) begin
                    hit_b = 1'b1;
`ifdef REG_WB_FWD_EN
                    fwd_b = ent_q[idx].data;
`endif
                end
            end
        end
    end

    assign bus.hazard_a = hit_a && (bus.rs != 5'd0);
    assign bus.hazard_b = hit_b && (bus.rt != 5'd0);

`ifdef REG_WB_FWD_EN
    assign bus.fwd_a_data = bus.hazard_a ? fwd_a : {DW{1'b0}};
    assign bus.fwd_b_data = bus.hazard_b ? fwd_b : {DW{1'b0}};
`else
    assign bus.fwd_a_data = {DW{1'b0}};
    assign bus.fwd_b_data = {DW{1'b0}};
`endif
endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed bench for reg_writeback_queue: scoreboard of expected register writes plus hazard/reset checks.
module tb_reg_writeback_queue;
    localparam int DEPTH = 4;
    localparam int DW    = 32;
`ifdef REG_WB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        logic [4:0]    rd;
        logic [DW-1:0] data;
    } wr_t;

    logic clk;
    logic rst;
    int   n_pass  = 0;
    int   n_total = 0;
    wr_t  sb[$];

    reg_writeback_queue_if #(.DEPTH(DEPTH), .DW(DW)) bus ();

    reg_writeback_queue #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Drive one result for a cycle; it is expected to be accepted at the next edge.
    task automatic push(input logic [4:0] rd, input logic [DW-1:0] d);
        wr_t e;
        bus.res_valid = 1'b1;
        bus.res_rd    = rd;
        bus.res_data  = d;
        #1;
        check("res_ready_before_push", bus.res_ready, 1);
        @(posedge clk);
        if (rd != 5'd0) begin
            e.rd   = rd;
            e.data = d;
            sb.push_back(e);
        end
        #1;
        bus.res_valid = 1'b0;
    endtask

    // Every write the DUT performs must be the oldest scoreboard entry.
    always @(negedge clk) begin
        if (rst) begin
            wr_t e;
            check("wr_en", bus.wr_en, (sb.size() != 0) && !bus.wr_stall);
            if (bus.wr_en && sb.size() != 0) begin
                e = sb.pop_front();
                check("wr_rd", bus.wr_rd, e.rd);
                check("wr_data", bus.wr_data, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] d5 [5];
        wr_t e;

        rst           = 1'b0;
        bus.res_valid = 1'b0;
        bus.res_rd    = '0;
        bus.res_data  = '0;
        bus.wr_stall  = 1'b0;
        bus.rs        = '0;
        bus.rt        = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_res_ready", bus.res_ready, 1);
        check("rst_wr_en", bus.wr_en, 0);
        check("rst_wr_rd", bus.wr_rd, 0);
        check("rst_wr_data", bus.wr_data, 0);
        check("rst_count", bus.count, 0);
        check("rst_hazard_a", bus.hazard_a, 0);
        check("rst_fwd_a", bus.fwd_a_data, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single result flows straight through
        push(5'd5, 32'h1234_5678);
        check("single_count", bus.count, 1);
        check("single_wr_en", bus.wr_en, 1);
        check("single_wr_rd", bus.wr_rd, 5);
        check("single_wr_data", bus.wr_data, 32'h1234_5678);
        @(posedge clk);
        #1;
        check("single_drained_count", bus.count, 0);
        check("single_drained_wr_en", bus.wr_en, 0);

        // r0 write discarded
        push(5'd0, 32'hDEAD_BEEF);
        check("r0_count", bus.count, 0);
        check("r0_res_ready", bus.res_ready, 1);
        check("r0_wr_en", bus.wr_en, 0);
        @(posedge clk);
        #1;

        // Stall fills the queue, fifth result waits
        bus.wr_stall = 1'b1;
        for (int i = 0; i < 5; i++) d5[i] = $urandom;
        for (int i = 0; i < 4; i++) push(5'(10 + i), d5[i]);
        check("full_count", bus.count, 4);
        check("full_res_ready", bus.res_ready, 0);
        bus.res_valid = 1'b1;
        bus.res_rd    = 5'd14;
        bus.res_data  = d5[4];
        bus.wr_stall  = 1'b0;
        #1;
        check("full_pop_res_ready", bus.res_ready, 0);
        @(posedge clk);
        #1;
        check("full_pop_count", bus.count, 3);
        check("after_pop_res_ready", bus.res_ready, 1);
        @(posedge clk);
        e.rd = 5'd14;
        e.data = d5[4];
        sb.push_back(e);
        #1;
        bus.res_valid = 1'b0;
        check("fifth_accepted_count", bus.count, 3);
        repeat (3) @(posedge clk);
        #1;
        check("stall_drain_count", bus.count, 0);
        check("stall_drain_sb_empty", sb.size(), 0);

        // Hazards with two pending writes to r7
        bus.wr_stall = 1'b1;
        push(5'd7, 32'h11);
        push(5'd7, 32'h22);
        push(5'd9, 32'h33);
        bus.rs = 5'd7;
        bus.rt = 5'd8;
        #1;
        check("haz_a_r7", bus.hazard_a, 1);
        check("haz_b_r8", bus.hazard_b, 0);
        check("fwd_a_r7", bus.fwd_a_data, FWD ? 32'h22 : 32'h0);
        check("fwd_b_r8", bus.fwd_b_data, 0);
        bus.rt = 5'd9;
        #1;
        check("haz_b_r9", bus.hazard_b, 1);
        check("fwd_b_r9", bus.fwd_b_data, FWD ? 32'h33 : 32'h0);
        bus.rs = 5'd0;
        #1;
        check("haz_a_r0", bus.hazard_a, 0);
        bus.rs = 5'd7;
        push(5'd12, 32'h44);
        bus.wr_stall = 1'b0;
        @(posedge clk);
        #1;
        check("middrain_count", bus.count, 3);
        check("haz_a_after_pop", bus.hazard_a, 1);
        check("fwd_a_after_pop", bus.fwd_a_data, FWD ? 32'h22 : 32'h0);

        // Reset mid-drain
        rst = 1'b0;
        sb.delete();
        #1;
        check("midrst_count", bus.count, 0);
        check("midrst_wr_en", bus.wr_en, 0);
        check("midrst_wr_rd", bus.wr_rd, 0);
        check("midrst_wr_data", bus.wr_data, 0);
        check("midrst_res_ready", bus.res_ready, 1);
        check("midrst_hazard_a", bus.hazard_a, 0);
        check("midrst_hazard_b", bus.hazard_b, 0);
        check("midrst_fwd_a", bus.fwd_a_data, 0);
        repeat (2) begin
            @(negedge clk);
            check("inrst_wr_en", bus.wr_en, 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("postrst_count", bus.count, 0);

        // Sustained throughput: one accept and one write per cycle
        for (int i = 0; i < 6; i++) begin
            push(5'(20 + i), 32'hA000_0000 + 32'(i));
            check("stream_count", bus.count, 1);
            bus.res_valid = 1'b1;
        end
        bus.res_valid = 1'b0;
        @(posedge clk);
        #1;
        check("stream_end_count", bus.count, 0);
        check("stream_sb_empty", sb.size(), 0);

        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
